// File: rtl/systolic_pkg.sv
// systolic_pkg: shared types and helpers for the systolic array datapath
package systolic_pkg;

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, FLUSH} feeder_state_t;

    localparam int DATA_SIZE = 4;
    localparam int SIZE = 3;
    localparam int CNT_W = $clog2(SIZE + 1);

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int lane_msb(input int c, input int dw, input int n);
        return (n - c) * dw - 1;
    endfunction

endpackage

// File: rtl/systolic_feeder_if.sv
// systolic_feeder_if: row handshakes and array-side streams of the feeder
interface systolic_feeder_if #(parameter int data_size = 4, parameter int size = 3);
    import systolic_pkg::*;

    logic start;
    logic [data_size*size-1:0] w_in;
    logic w_valid;
    logic w_ready;
    logic [data_size*size-1:0] x_in;
    logic x_valid;
    logic x_ready;
    logic set_w;
    logic [data_size*size-1:0] w_stream;
    logic [data_size*size-1:0] data_stream;
    logic busy;
    logic done;

    modport master (
        output start, w_in, w_valid, x_in, x_valid,
        input w_ready, x_ready, set_w, w_stream, data_stream, busy, done
    );

    modport slave (
        input start, w_in, w_valid, x_in, x_valid,
        output w_ready, x_ready, set_w, w_stream, data_stream, busy, done
    );

endinterface

// File: rtl/systolic_feeder_skew_delay.sv
// skew_delay: fixed-depth register delay line, depth 0 is a plain wire
module skew_delay #(parameter int width = 4, parameter int depth = 0) (
    input  logic clk,
    input  logic rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);
    if (depth == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = &{1'b0, clk, rst};
        assign q = d;
    end else begin : g_line
        logic [width-1:0] sr [depth];
        // shift one stage per cycle, never stalls
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sr <= '{default: '0};
            end else begin
                sr[0] <= d;
                for (int i = 1; i < depth; i++) sr[i] <= sr[i-1];
            end
        end
        assign q = sr[depth-1];
    end
endmodule

// File: rtl/systolic_feeder.sv
// systolic_feeder: loads weights then streams diagonally skewed input rows
module systolic_feeder import systolic_pkg::*; #(
    parameter int data_size = 4,
    parameter int size = 3
) (
    input logic clk,
    input logic rst,
    systolic_feeder_if.slave bus
);
    localparam int W = data_size * size;
    localparam int CW = cnt_w(size);
    localparam logic [CW-1:0] LAST = CW'(size - 1);
    localparam logic [CW-1:0] FLAST = CW'(size > 1 ? size - 2 : 0);

    feeder_state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [W-1:0] xr, ds, w_stream_r;
    logic wt, xt, set_w_r, done_r, done_n;

    assign wt = bus.w_valid && bus.w_ready;
    assign xt = bus.x_valid && bus.x_ready;
    assign bus.w_ready = state == LOAD_W;
    assign bus.x_ready = state == STREAM;
    assign bus.busy = state != IDLE || done_r;
    assign bus.done = done_r;
    assign bus.set_w = set_w_r;
    assign bus.w_stream = w_stream_r;
    assign bus.data_stream = ds;

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // next state and end-of-job pulse; start is refused while done is still showing
    always_comb begin
        state_n = state;
        done_n = 1'b0;
        case (state)
            IDLE:    state_n = bus.start && !done_r ? LOAD_W : IDLE;
            LOAD_W:  state_n = wt && cnt == LAST ? STREAM : LOAD_W;
            STREAM: begin
                state_n = xt && cnt == LAST ? (size == 1 ? IDLE : FLUSH) : STREAM;
                done_n = size == 1 && xt && cnt == LAST;
            end
            FLUSH: begin
                state_n = cnt == FLAST ? IDLE : FLUSH;
                done_n = cnt == FLAST;
            end
            default: state_n = IDLE;
        endcase
    end

    // row/flush counter, cleared whenever a new state is entered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt <= '0;
        else if (state_n != state) cnt <= '0;
        else if (wt || xt || state == FLUSH) cnt <= cnt + CW'(1);
    end

    // weight register, input register (zero row when nothing is accepted) and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            set_w_r <= 1'b0;
            w_stream_r <= '0;
            xr <= '0;
            done_r <= 1'b0;
        end else begin
            set_w_r <= wt;
            w_stream_r <= wt ? bus.w_in : w_stream_r;
            xr <= xt ? bus.x_in : '0;
            done_r <= done_n;
        end
    end

    for (genvar c = 0; c < size; c++) begin : g_lane
        skew_delay #(.width(data_size), .depth(c)) u_skew (
            .clk(clk),
            .rst(rst),
            .d(xr[lane_msb(c, data_size, size) -: data_size]),
            .q(ds[lane_msb(c, data_size, size) -: data_size])
        );
    end
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: randomized scoreboard bench for the skewing feeder
module tb_systolic_feeder;
    localparam int DS = 4;
    localparam int S = 3;
    localparam int W = DS * S;

    typedef struct packed {
        logic wr, xr, busy, done, sw;
        logic [W-1:0] ws, ds;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int vec = 0;
    int bad = 0;

    systolic_feeder_if #(.data_size(DS), .size(S)) bus ();

    systolic_feeder #(.data_size(DS), .size(S)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vec++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic check_zero(input string nm);
        chk({nm, ".set_w"}, 32'(bus.set_w), 0);
        chk({nm, ".w_stream"}, 32'(bus.w_stream), 0);
        chk({nm, ".data_stream"}, 32'(bus.data_stream), 0);
        chk({nm, ".w_ready"}, 32'(bus.w_ready), 0);
        chk({nm, ".x_ready"}, 32'(bus.x_ready), 0);
        chk({nm, ".busy"}, 32'(bus.busy), 0);
        chk({nm, ".done"}, 32'(bus.done), 0);
    endtask

    // reference model: job phase, rows accepted, cycles until done, and the
    // history of rows injected into the skew line (newest first)
    int ph, n, d;
    logic [W-1:0] lastw, row, tmp;
    logic [W-1:0] inj[$];
    logic [W-1:0] wq[$];
    exp_t cq[$];
    exp_t e, m;
    bit wt, xt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ph = 0; n = 0; d = 0; lastw = '0;
            cq.delete(); wq.delete(); inj.delete();
            for (int k = 0; k < S; k++) inj.push_back('0);
        end else begin
            wt = ph == 1 && bus.w_valid;
            xt = ph == 2 && bus.x_valid;
            row = xt ? bus.x_in : '0;
            case (ph)
                0: if (bus.start) begin ph = 1; n = 0; end
                1: if (wt) begin
                    lastw = bus.w_in;
                    wq.push_back(bus.w_in);
                    n++;
                    if (n == S) begin ph = 2; n = 0; end
                end
                2: if (xt) begin
                    n++;
                    if (n == S) begin ph = 3; d = S - 1; n = 0; end
                end
                default: if (d == 0) ph = 0; else d--;
            endcase
            inj.push_front(row);
            void'(inj.pop_back());
            e = '0;
            e.wr = ph == 1;
            e.xr = ph == 2;
            e.busy = ph != 0;
            e.done = ph == 3 && d == 0;
            e.sw = wt;
            e.ws = lastw;
            for (int c = 0; c < S; c++) begin
                tmp = inj[c];
                e.ds[(S-c)*DS-1 -: DS] = tmp[(S-c)*DS-1 -: DS];
            end
            cq.push_back(e);
        end
    end

    // monitor: compare every presented cycle; weight rows popped on set_w
    always @(negedge clk) begin
        if (!rst && cq.size() > 0) begin
            m = cq.pop_front();
            chk("w_ready", 32'(bus.w_ready), 32'(m.wr));
            chk("x_ready", 32'(bus.x_ready), 32'(m.xr));
            chk("busy", 32'(bus.busy), 32'(m.busy));
            chk("done", 32'(bus.done), 32'(m.done));
            chk("set_w", 32'(bus.set_w), 32'(m.sw));
            chk("w_stream_hold", 32'(bus.w_stream), 32'(m.ws));
            chk("data_stream", 32'(bus.data_stream), 32'(m.ds));
            if (bus.set_w) begin
                if (wq.size() == 0) begin
                    vec++; bad++;
                    $display("FAIL w_row: set_w with no row expected, got %0h", bus.w_stream);
                end else begin
                    chk("w_row", 32'(bus.w_stream), 32'(wq.pop_front()));
                end
            end
        end
    end

    task automatic run_job(input int bub, input bit junk, input bit dir, input int abort);
        logic [W-1:0] dr[3] = '{12'h123, 12'h456, 12'h789};
        logic [W-1:0] wr[3];
        logic [W-1:0] xv[3];
        int i, g;
        for (int k = 0; k < S; k++) begin
            wr[k] = dir ? dr[k] : W'($urandom);
            xv[k] = dir ? dr[k] : W'($urandom);
        end
        @(negedge clk); bus.start = 1'b1;
        @(negedge clk); bus.start = 1'b0;
        i = 0; g = 0;
        while (i < S && g < 400) begin
            bus.w_valid = $urandom_range(99) >= bub;
            bus.w_in = wr[i];
            bus.x_valid = junk;
            bus.x_in = W'($urandom);
            if (bus.w_valid && bus.w_ready) i++;
            g++;
            @(negedge clk);
        end
        bus.w_valid = junk;
        bus.w_in = 12'hfff;
        bus.x_valid = 1'b0;
        i = 0;
        while (i < S && g < 400) begin
            if (abort != 0 && i == abort) break;
            bus.x_valid = $urandom_range(99) >= bub;
            bus.x_in = xv[i];
            bus.start = junk;
            if (bus.x_valid && bus.x_ready) i++;
            g++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.w_valid = 1'b0;
        bus.x_valid = 1'b0;
        if (g >= 400) begin
            vec++; bad++;
            $display("FAIL handshake_timeout: %0d cycles, required under 400", g);
        end
        if (abort != 0) begin
            #2 rst = 1'b1;
            #1 check_zero("mid_reset");
            @(negedge clk) rst = 1'b0;
            return;
        end
        g = 0;
        while (bus.busy && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (g >= 50) begin
            vec++; bad++;
            $display("FAIL busy_timeout: busy=%0b, required 0", bus.busy);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.w_in = '0;
        bus.w_valid = 1'b0;
        bus.x_in = '0;
        bus.x_valid = 1'b0;
        #2 check_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_job(0, 1'b0, 1'b1, 0);
        run_job(0, 1'b1, 1'b1, 0);
        run_job(40, 1'b0, 1'b1, 0);
        run_job(0, 1'b0, 1'b1, 2);
        run_job(0, 1'b0, 1'b1, 0);
        for (int j = 0; j < 20; j++) run_job(30, j[0], 1'b0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end
endmodule

// File: doc/systolic_feeder.md
# systolic_feeder

Upstream feeder for the `systolic` array. It accepts the weight matrix and the input matrix as whole rows over valid/ready handshakes. It drives `set_w`/`w_stream` for weight loading, then emits a diagonally skewed `data_stream` in which lane c is delayed c cycles. This lets the array consume un-skewed matrices produced by the rest of the datapath.

## Interface
- `data_size`, default 4: bits per element.
- `size`, default 3: array dimension, i.e. lanes per row and rows per matrix.

Ports:
- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a job; honoured only in IDLE.
- `w_in`  in  data_size*size  weight row; lane c occupies `[(size-c)*data_size-1 -: data_size]`.
- `w_valid`  in  1  `w_in` holds a valid row.
- `w_ready`  out  1  feeder accepts a weight row this cycle.
- `x_in`  in  data_size*size  input row; same lane layout as `w_in`.
- `x_valid`  in  1  `x_in` holds a valid row.
- `x_ready`  out  1  feeder accepts an input row this cycle.
- `set_w`  out  1  to `systolic.set_w`.
- `w_stream`  out  data_size*size  to `systolic.w_stream`.
- `data_stream`  out  data_size*size  to `systolic.data_stream`; same lane layout.
- `busy`  out  1  a job is in progress.
- `done`  out  1  one-cycle pulse when the last skewed element is on `data_stream`.

## Operation
- FSM states:
  - IDLE: `start` moves to LOAD_W.
  - LOAD_W: ends after `size` weight rows are accepted; then STREAM.
  - STREAM: ends after `size` input rows are accepted; then FLUSH.
  - FLUSH: lasts `size-1` cycles, then IDLE.
- Handshakes:
  - `w_ready`=1 only in LOAD_W; `x_ready`=1 only in STREAM.
  - A transfer occurs when valid && ready.
  - Rows beyond the count are never accepted, because ready drops in the cycle after the last transfer.
- Weights:
  - On each weight transfer, `w_stream` registers the row and `set_w`=1 for exactly one cycle.
  - Otherwise `set_w`=0 and `w_stream` holds its last value.
- Skew line:
  - Lane c is a c-stage delay behind a 1-stage input register, so lane c of row r appears c+1 cycles after acceptance.
  - The line advances every cycle in every state; it has no stall.
  - Any cycle without an input transfer injects an all-zero row. A STREAM bubble therefore inserts a zero row into the array, and the downstream collector accounts for it.
- Counters:
  - Row counter is `$clog2(size+1)` bits, cleared on every state entry.
  - Flush counter counts 0..size-2.
  - For `size`=1, FLUSH is skipped: STREAM goes directly to IDLE and `done` fires in the cycle after the last transfer.
- `start` outside IDLE is ignored. Concurrent `w_valid`/`x_valid` in the wrong state are ignored.
- Elements pass through unmodified; no arithmetic is performed.

## Timing
- Reset values: state IDLE, all counters 0, all skew registers 0.
- Outputs at reset: `set_w`=0, `w_stream`=0, `data_stream`=0, `w_ready`=0, `x_ready`=0, `busy`=0, `done`=0.
- Reset asserted mid-job clears everything immediately (asynchronous). No partial job resumes.
- `start` at cycle t: `busy`=1 and `w_ready`=1 from t+1.
- Weight transfer at cycle t: `set_w`=1 and `w_stream`=row at t+1.
- Input transfer at cycle t: lane c = row lane c at cycle t+1+c.
- Last input transfer at cycle t:
  - `done`=1 at t+size, the cycle lane `size-1` of the last row is presented.
  - `busy` falls at t+size+1.
  - `start` is accepted again from t+size+1.
- Minimum job length (no bubbles): 1 + size + size + (size-1) cycles from `start` to `done`.

## Structure
- Shared package `systolic_pkg` contains:
  - the `feeder_state_t` enum (IDLE, LOAD_W, STREAM, FLUSH);
  - a lane-slice helper function returning the MSB index for lane c;
  - the counter-width localparam expression.
- One sub-module, `skew_delay`, with parameters width and depth; depth 0 is a wire. It is instantiated once per lane via generate.
- The top level holds the FSM, counters, weight register and input register.

## Test plan
All scenarios use `data_size`=4, `size`=3.
- Reset/idle: assert `rst` mid-cycle → all outputs 0 immediately; pulse `start` after release → `w_ready`=1 next cycle.
- Weight load: rows 1 2 3 / 4 5 6 / 7 8 9 with `w_valid` held high → `set_w`=1 for 3 consecutive cycles, `w_stream` = 0x123, 0x456, 0x789, then `set_w`=0.
- Skew: input rows 1 2 3 / 4 5 6 / 7 8 9 back-to-back → `data_stream` over 5 cycles = 0x100, 0x420, 0x753, 0x086, 0x009; `done` on the 0x009 cycle.
- Bubble: drop `x_valid` for 1 cycle between rows 1 and 2 → zero row inserted, giving 0x100, 0x020, 0x403, 0x750, 0x086, 0x009.
- Protocol: `start` during STREAM is ignored; `x_valid` during LOAD_W gets no transfer; a 4th weight row is not accepted.
- Reset mid-STREAM after 2 input rows → outputs clear, state IDLE; a following full job produces the skew-scenario sequence exactly.
